// File: rtl/dvp_tx_if.sv
// Pixel stream into the DVP transmitter and the camera-side byte bus out of it.
interface dvp_tx_if;
    logic        pix_valid;
    logic        pix_ready;
    logic [15:0] pix_data;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_data;

    modport master (
        output pix_valid, pix_data,
        input  pix_ready, cam_vsync, cam_href, cam_data
    );

    modport slave (
        input  pix_valid, pix_data,
        output pix_ready, cam_vsync, cam_href, cam_data
    );
endinterface

// File: rtl/dvp_tx.sv
// DVP camera transmitter: RGB565 pixels in, vsync/href/byte stream out, high byte first.
// Colour-bar source is compiled in only with DVP_TX_PATTERN_EN defined.
module dvp_tx #(
    parameter int H_PIXEL   = 480,
    parameter int V_PIXEL   = 272,
    parameter int H_BLANK   = 160,
    parameter int VSYNC_LEN = 3,
    parameter int V_BACK    = 10,
    parameter int V_FRONT   = 4
) (
    input  logic    cam_pclk,
    input  logic    rst_n,
    input  logic    enable,
    input  logic    pattern_sel,
    dvp_tx_if.slave bus,
    output logic    frame_start,
    output logic    frame_done,
    output logic    underrun
);
    localparam int LINE_CYC  = 2 * H_PIXEL + H_BLANK;
    localparam int MAX_A     = (VSYNC_LEN > V_BACK) ? VSYNC_LEN : V_BACK;
    localparam int MAX_B     = (V_PIXEL > V_FRONT) ? V_PIXEL : V_FRONT;
    localparam int MAX_LINES = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int COL_W     = $clog2(LINE_CYC);
    localparam int LINE_W    = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_CYC - 1);
    localparam logic [COL_W-1:0] HREF_END = COL_W'(2 * H_PIXEL);

    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

    state_t            state, state_nxt;
    logic [COL_W-1:0]  col, col_nxt, col_adv;
    logic [LINE_W-1:0] line, line_nxt, stage_last;
    logic              line_end, stage_done;
    logic              act_nxt, slot, href_d, start_d, done_d;
    logic              src_vld, pat_on;
    logic [15:0]       src_dat;
    logic [7:0]        lo_byte;

    assign line_end   = (col == LAST_COL);
    assign col_adv    = line_end ? '0 : col + 1'b1;
    assign stage_done = (line == stage_last);

    always_comb begin
        stage_last = '0;
        case (state)
            VSYNC:   stage_last = LINE_W'(VSYNC_LEN - 1);
            VBACK:   stage_last = LINE_W'(V_BACK - 1);
            ACTIVE:  stage_last = LINE_W'(V_PIXEL - 1);
            VFRONT:  stage_last = LINE_W'(V_FRONT - 1);
            default: stage_last = '0;
        endcase
    end

    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            col   <= '0;
            line  <= '0;
        end else begin
            state <= state_nxt;
            col   <= col_nxt;
            line  <= line_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        line_nxt  = line;
        if (state == IDLE) begin
            if (enable) state_nxt = VSYNC;
        end else begin
            col_nxt = col_adv;
            if (line_end) begin
                if (stage_done) begin
                    line_nxt = '0;
                    case (state)
                        VSYNC:   state_nxt = VBACK;
                        VBACK:   state_nxt = ACTIVE;
                        ACTIVE:  state_nxt = VFRONT;
                        default: state_nxt = enable ? VSYNC : IDLE;
                    endcase
                end else begin
                    line_nxt = line + 1'b1;
                end
            end
        end
    end

    // Next-cycle decode from registered state only, so pix_ready has no path from enable.
    assign act_nxt = ((state == ACTIVE) && !(line_end && stage_done)) ||
                     ((state == VBACK) && line_end && stage_done);
    assign href_d  = act_nxt && (col_adv < HREF_END);
    assign slot    = href_d && !col_adv[0];
    assign start_d = (state_nxt == VSYNC) && (state != VSYNC);
    assign done_d  = (state == VFRONT) && (line == LINE_W'(V_FRONT - 1)) &&
                     (col_adv == LAST_COL);

`ifdef DVP_TX_PATTERN_EN
    localparam int BAR_W = (H_PIXEL >= 8) ? H_PIXEL / 8 : 1;
    logic [COL_W-1:0] bar;
    logic [2:0]       bar_sel;
    logic [15:0]      pat_pix;

    always_comb begin
        bar     = (col_adv >> 1) / COL_W'(BAR_W);
        bar_sel = (bar > COL_W'(7)) ? 3'd7 : bar[2:0];
        pat_pix = 16'h0000;
        case (bar_sel)
            3'd0:    pat_pix = 16'hFFFF;
            3'd1:    pat_pix = 16'hFFE0;
            3'd2:    pat_pix = 16'h07FF;
            3'd3:    pat_pix = 16'h07E0;
            3'd4:    pat_pix = 16'hF81F;
            3'd5:    pat_pix = 16'hF800;
            3'd6:    pat_pix = 16'h001F;
            default: pat_pix = 16'h0000;
        endcase
    end

    assign pat_on  = pattern_sel;
    assign src_vld = pattern_sel | bus.pix_valid;
    assign src_dat = pattern_sel ? pat_pix : bus.pix_data;
`else
    wire unused_pattern_sel = pattern_sel;
    assign pat_on  = 1'b0;
    assign src_vld = bus.pix_valid;
    assign src_dat = bus.pix_data;
`endif

    assign bus.pix_ready = slot && !pat_on;

    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            bus.cam_vsync <= 1'b0;
            bus.cam_href  <= 1'b0;
            bus.cam_data  <= 8'h00;
            lo_byte       <= 8'h00;
            frame_start   <= 1'b0;
            frame_done    <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            bus.cam_vsync <= (state_nxt == VSYNC);
            bus.cam_href  <= href_d;
            frame_start   <= start_d;
            frame_done    <= done_d;
            if (slot) begin
                bus.cam_data <= src_vld ? src_dat[15:8] : 8'h00;
                lo_byte      <= src_vld ? src_dat[7:0]  : 8'h00;
            end else if (href_d) begin
                bus.cam_data <= lo_byte;
            end else begin
                bus.cam_data <= 8'h00;
            end
            underrun <= start_d ? 1'b0 : (underrun | (slot && !src_vld));
        end
    end
endmodule
